// File: rtl/sdram_refresh_scheduler.sv
// SDRAM auto-refresh scheduler: syncs the C1 timebase, counts refresh intervals, accumulates owed
// refreshes as debt and hands them to the sequencer. Optional pull-in credit: `define REFRESH_PULLIN_EN.
module sdram_refresh_scheduler #(
  parameter int TICK_DIV     = 28,
  parameter int CNT_W        = 8,
  parameter int DEBT_MAX     = 8,
  parameter int DEBT_W       = 4,
  parameter int URGENT_LEVEL = 6,
  parameter int GUARD_CYCLES = 5,
  parameter int PULLIN_MAX   = 4
) (
  input  logic              i_clk,
  input  logic              i_refresh_rst,
  input  logic              i_tick_in,
  input  logic              i_enable,
  input  logic              i_busy,
  input  logic              i_ref_ack,
  output logic              o_ref_req,
  output logic              o_ref_urgent,
  output logic [DEBT_W-1:0] o_debt,
  output logic              o_overflow
);
  localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [CNT_W-1:0]  L_CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  L_CNT_ONE  = CNT_W'(1);
  localparam logic [DEBT_W-1:0] L_DEBT_MAX = DEBT_W'(DEBT_MAX);
  localparam logic [DEBT_W-1:0] L_DEBT_ONE = DEBT_W'(1);
  localparam logic [DEBT_W-1:0] L_URGENT   = DEBT_W'(URGENT_LEVEL);
  localparam logic [GRD_W-1:0]  L_GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [GRD_W-1:0]  L_GRD_ONE  = GRD_W'(1);

  // [0],[1] form the synchroniser; [2] is the previous synchronised level for edge detect
  logic [2:0]        r_sync;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DEBT_W-1:0] r_debt, w_debt_nxt;
  logic [1:0]        r_state, w_state_nxt;
  logic [GRD_W-1:0]  r_grd, w_grd_nxt;
  logic              r_req, r_urgent, r_ovf, w_ovf_nxt;
  logic              w_tick, w_owe, w_ack, w_pullin;

`ifdef REFRESH_PULLIN_EN
  localparam int CR_W = $clog2(PULLIN_MAX + 1);
  localparam logic [CR_W-1:0] L_CR_MAX = CR_W'(PULLIN_MAX);
  localparam logic [CR_W-1:0] L_CR_ONE = CR_W'(1);
  logic [CR_W-1:0] r_credit, w_credit_nxt;
  logic [2:0]      r_idle_cnt;

  // Saturating count of consecutive CLK cycles with the sequencer idle
  always_ff @(posedge i_clk or posedge i_refresh_rst) begin
    if (i_refresh_rst)                r_idle_cnt <= 3'd0;
    else if (!i_enable || i_busy)     r_idle_cnt <= 3'd0;
    else if (r_idle_cnt != 3'd4)      r_idle_cnt <= r_idle_cnt + 3'd1;
    else                              r_idle_cnt <= r_idle_cnt;
  end

  assign w_pullin = (r_debt == '0) && (r_idle_cnt == 3'd4) && (r_credit < L_CR_MAX);
`else
  logic [1:0] w_unused;
  assign w_unused = {i_busy, (PULLIN_MAX > 0)};
  assign w_pullin = 1'b0;
`endif

  assign w_tick = r_sync[1] & ~r_sync[2];
  assign w_owe  = i_enable & w_tick & (r_cnt == L_CNT_LAST);
  assign w_ack  = i_enable & (r_state == S_REQ) & i_ref_ack;

  // Interval counter next value
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_enable)                w_cnt_nxt = '0;
    else if (w_tick && (r_cnt == L_CNT_LAST)) w_cnt_nxt = '0;
    else if (w_tick)              w_cnt_nxt = r_cnt + L_CNT_ONE;
    else                          w_cnt_nxt = r_cnt;
  end

  // Debt / credit / overflow update; a simultaneous owe and ACK cancel out
  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_nxt  = r_ovf;
`ifdef REFRESH_PULLIN_EN
    w_credit_nxt = r_credit;
`endif
    if (!i_enable) begin
      w_debt_nxt = '0;
`ifdef REFRESH_PULLIN_EN
      w_credit_nxt = '0;
`endif
    end else if (w_owe && !w_ack) begin
`ifdef REFRESH_PULLIN_EN
      if (r_credit != '0)               w_credit_nxt = r_credit - L_CR_ONE;
      else if (r_debt == L_DEBT_MAX)    w_ovf_nxt    = 1'b1;
      else                              w_debt_nxt   = r_debt + L_DEBT_ONE;
`else
      if (r_debt == L_DEBT_MAX)         w_ovf_nxt    = 1'b1;
      else                              w_debt_nxt   = r_debt + L_DEBT_ONE;
`endif
    end else if (w_ack && !w_owe) begin
      if (r_debt != '0)                 w_debt_nxt   = r_debt - L_DEBT_ONE;
`ifdef REFRESH_PULLIN_EN
      else if (r_credit != L_CR_MAX)    w_credit_nxt = r_credit + L_CR_ONE;
`endif
      else                              w_debt_nxt   = r_debt;
    end else begin
      w_debt_nxt = r_debt;
    end
  end

  // Handshake FSM and post-ACK guard timer
  always_comb begin
    w_state_nxt = r_state;
    w_grd_nxt   = r_grd;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_grd_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_debt != '0) || w_pullin) w_state_nxt = S_REQ;
          else                            w_state_nxt = S_IDLE;
        end
        S_REQ: begin
          if (w_ack) begin
            w_state_nxt = S_GUARD;
            w_grd_nxt   = L_GRD_LOAD;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_GUARD: begin
          if (r_grd == '0) w_state_nxt = (w_debt_nxt != '0) ? S_REQ : S_IDLE;
          else             w_grd_nxt   = r_grd - L_GRD_ONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_grd_nxt   = '0;
        end
      endcase
    end
  end

  // State registers; REF_REQ mirrors the next state so it is high exactly while in S_REQ
  always_ff @(posedge i_clk or posedge i_refresh_rst) begin
    if (i_refresh_rst) begin
      r_sync   <= 3'b000;
      r_cnt    <= '0;
      r_debt   <= '0;
      r_ovf    <= 1'b0;
      r_state  <= S_IDLE;
      r_grd    <= '0;
      r_req    <= 1'b0;
      r_urgent <= 1'b0;
`ifdef REFRESH_PULLIN_EN
      r_credit <= '0;
`endif
    end else begin
      r_sync   <= {r_sync[1:0], i_tick_in};
      r_cnt    <= w_cnt_nxt;
      r_debt   <= w_debt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_state  <= w_state_nxt;
      r_grd    <= w_grd_nxt;
      r_req    <= (w_state_nxt == S_REQ);
      r_urgent <= (w_debt_nxt >= L_URGENT);
`ifdef REFRESH_PULLIN_EN
      r_credit <= w_credit_nxt;
`endif
    end
  end

  assign o_ref_req    = r_req;
  assign o_ref_urgent = r_urgent;
  assign o_debt       = r_debt;
  assign o_overflow   = r_ovf;
endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Bench for sdram_refresh_scheduler: directed steps plus randomized ticks/ACKs checked against
// an interval/debt model derived from the refresh rules (default build, pull-in disabled).
module tb_sdram_refresh_scheduler;
  localparam int TICK_DIV     = 28;
  localparam int DEBT_MAX     = 8;
  localparam int URGENT_LEVEL = 6;
  localparam int GUARD_CYCLES = 5;
  localparam int HOLD_CAP     = 12;

  logic       clk, rst, tick_in, enable, busy, ack;
  logic       busy_rand = 1'b1;
  logic       ref_req, ref_urgent, overflow;
  logic [3:0] debt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int m_ticks, m_debt;
  bit m_ovf, m_en;

  sdram_refresh_scheduler dut (
    .i_clk        (clk),
    .i_refresh_rst(rst),
    .i_tick_in    (tick_in),
    .i_enable     (enable),
    .i_busy       (busy),
    .i_ref_ack    (ack),
    .o_ref_req    (ref_req),
    .o_ref_urgent (ref_urgent),
    .o_debt       (debt),
    .o_overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".debt"},     32'(debt),       32'(m_debt));
    check({tag, ".req"},      32'(ref_req),    32'(m_en && (m_debt != 0)));
    check({tag, ".urgent"},   32'(ref_urgent), 32'(m_debt >= URGENT_LEVEL));
    check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
  endtask

  // Every TICK_DIV counted rising edges owe one refresh; a full debt turns the owe into overflow
  function automatic void m_tick();
    if (m_en) begin
      m_ticks++;
      if (m_ticks % TICK_DIV == 0) begin
        if (m_debt == DEBT_MAX) m_ovf = 1'b1;
        else                    m_debt++;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    tick_in = 1'b1;
    m_tick();
    repeat ($urandom_range(3, 6)) @(negedge clk);
    tick_in = 1'b0;
    repeat ($urandom_range(4, 8)) @(negedge clk);
  endtask

  // Count REF_REQ-low cycles after an accepted ACK; optionally poke ACK again during the guard
  task automatic guard_lows(input string tag, input bit extra_in_guard);
    int lows;
    lows = 0;
    for (int i = 0; i < HOLD_CAP; i++) begin
      if (ref_req) break;
      ack = extra_in_guard && (i == 1);
      lows++;
      @(negedge clk);
    end
    ack = 1'b0;
    check({tag, ".guard_lows"}, 32'(lows), 32'((m_debt > 0) ? GUARD_CYCLES : HOLD_CAP));
  endtask

  task automatic do_ack(input string tag, input bit extra_in_guard);
    check({tag, ".req_before"}, 32'(ref_req), 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_debt--;
    guard_lows(tag, extra_in_guard);
    repeat (2) @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; tick_in = 1'b0; enable = 1'b0; ack = 1'b0;
    m_ticks = 0; m_debt = 0; m_ovf = 1'b0; m_en = 1'b0;
    #12;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; m_en = 1'b1;

    // Step 1: first interval, REF_REQ latency from the 28th edge
    repeat (TICK_DIV - 1) tick();
    check_state("t1.pre");
    @(negedge clk);
    tick_in = 1'b1;
    m_tick();
    lat = 0;
    while (!ref_req && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("t1.req_latency_le4", 32'(lat <= 4), 32'd1);
    tick_in = 1'b0;
    repeat (6) @(negedge clk);
    check_state("t1");

    // Step 2: ACK, guard, then idle; no request appears from an idle bus
    do_ack("t2", 1'b0);
    busy_rand = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (ref_req) seen++;
    end
    check("t2.no_pullin", 32'(seen), 32'd0);
    busy_rand = 1'b1;

    // Step 3: urgency threshold, saturation, sticky overflow
    repeat (6 * TICK_DIV) tick();
    check_state("t3.six");
    do_ack("t3.ack", 1'b0);
    repeat (4 * TICK_DIV) tick();
    check_state("t3.sat");
    repeat (5) do_ack("t3.drain", 1'b0);

    // Step 4: owe and ACK on the same edge, then ACK during guard
    while (m_ticks % TICK_DIV != TICK_DIV - 1) tick();
    check("t4.req_before", 32'(ref_req), 32'd1);
    tick_in = 1'b1;
    m_tick();
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_debt--;
    guard_lows("t4.align", 1'b0);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    check_state("t4.align");
    do_ack("t4.guard", 1'b1);

    // ENABLE low clears debt and interval phase but keeps overflow
    @(negedge clk);
    enable = 1'b0; m_en = 1'b0; m_debt = 0; m_ticks = 0;
    repeat (100) tick();
    check_state("en_low");
    enable = 1'b1; m_en = 1'b1;
    repeat (TICK_DIV - 1) tick();
    check_state("en_restart.pre");
    tick();
    check_state("en_restart");

    // Step 5: asynchronous reset mid-request
    repeat (3 * TICK_DIV) tick();
    check_state("t5.pre");
    #2 rst = 1'b1;
    #1;
    check("t5.async_req",    32'(ref_req),    32'd0);
    check("t5.async_debt",   32'(debt),       32'd0);
    check("t5.async_urgent", 32'(ref_urgent), 32'd0);
    check("t5.async_ovf",    32'(overflow),   32'd0);
    m_debt = 0; m_ovf = 1'b0; m_ticks = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized mix of ticks and ACKs
    repeat (600) begin
      if (m_debt > 0 && $urandom_range(0, 24) == 0) do_ack("rnd.ack", 1'($urandom_range(0, 1)));
      else begin
        tick();
        check_state("rnd.tick");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sdram_refresh_scheduler.md
Name: sdram_refresh_scheduler

Overview:
Parametrised SDRAM auto-refresh scheduler. It is the successor to the fixed single-threshold refresh counter in the chip RAM controller. A slow timebase tick (C1 domain) is synchronised into the fast controller clock, and refresh intervals are counted. Owed refreshes are accumulated as debt so that DMA/CPU cycles can postpone them. REF_REQ/REF_ACK is a handshake with the SDRAM sequencer, and REF_URGENT asks the sequencer to pre-empt CPU cycles.

Parameters:
TICK_DIV, 28, slow ticks per refresh interval (7.8us at ~3.55MHz)
CNT_W, 8, interval counter width; must hold TICK_DIV-1
DEBT_MAX, 8, max postponed refreshes (JEDEC limit)
DEBT_W, 4, debt counter width; must hold DEBT_MAX
URGENT_LEVEL, 6, debt at or above which REF_URGENT asserts
GUARD_CYCLES, 5, CLK cycles REF_REQ is held low after each ACK (tRFC at 80MHz)
PULLIN_MAX, 4, max refreshes issued in advance (optional feature only)

Ports:
CLK  input  1  controller clock (80MHz); all logic on rising edge
REFRESH_RST  input  1  reset, asynchronous, active-high
TICK_IN  input  1  slow timebase (C1), asynchronous to CLK
ENABLE  input  1  high once SDRAM initialisation is complete
BUSY  input  1  sequencer is running a DMA/CPU cycle
REF_ACK  input  1  one-CLK pulse when sequencer issues AUTOREFRESH
REF_REQ  output  1  refresh wanted
REF_URGENT  output  1  debt >= URGENT_LEVEL
DEBT  output  DEBT_W  current owed refresh count
OVERFLOW  output  1  sticky: a refresh interval expired while debt was saturated

Behaviour:
- Reset (REFRESH_RST high, async):
  - REF_REQ=0, REF_URGENT=0, DEBT=0, OVERFLOW=0.
  - Interval counter=0, sync flops=0, FSM=S_IDLE, guard counter=0, credit=0.
  - Reset mid-handshake drops REF_REQ immediately.
- Tick sync:
  - 2-flop synchroniser, then rising-edge detect gives a one-CLK tick_pulse.
  - tick_pulse occurs 2-3 CLK after the TICK_IN rise.
  - Only rising TICK_IN edges count.
- Interval counter:
  - Increments on tick_pulse.
  - At TICK_DIV-1 with tick_pulse: wraps to 0 and generates a one-cycle owe event.
- Debt update, per cycle, registered:
  - owe only: DEBT+1.
  - accepted ACK only: DEBT-1.
  - Both in the same cycle: DEBT unchanged.
  - owe while DEBT==DEBT_MAX: DEBT holds and OVERFLOW sets. OVERFLOW clears only on reset.
  - Accepted ACK at DEBT==0 never underflows; see Optional Feature.
- FSM:
  - S_IDLE: REF_REQ=0. Goes to S_REQ when DEBT!=0.
  - S_REQ: REF_REQ=1. REF_ACK is accepted only in this state. On ACK, guard counter loads GUARD_CYCLES-1 and the FSM goes to S_GUARD.
  - S_GUARD: REF_REQ=0 while the counter decrements. At 0, the FSM goes to S_REQ if DEBT!=0 after update, else S_IDLE.
  - REF_ACK outside S_REQ is ignored; DEBT is not changed.
- REF_REQ is registered.
  - DEBT 0->1 gives REF_REQ high on the next CLK edge after DEBT updates.
  - REF_REQ is not conditioned on BUSY; the sequencer arbitrates.
- REF_URGENT is registered from the post-update DEBT and is independent of FSM state.
- ENABLE low:
  - Interval counter, DEBT and credit are held at 0; FSM forced to S_IDLE; REF_REQ=0.
  - OVERFLOW is retained.
  - Counting restarts from 0 on the first cycle ENABLE is high.
- Back-to-back: with DEBT=N and prompt ACKs, the sequencer sees N REQ/ACK pairs, each separated by exactly GUARD_CYCLES of REF_REQ low.

Optional Feature:
Macro REFRESH_PULLIN_EN.
- Defined:
  - Adds a credit counter, 0..PULLIN_MAX.
  - In S_IDLE, when DEBT==0, BUSY has been low for 4 consecutive CLK, and credit<PULLIN_MAX, the FSM enters S_REQ (pull-in request).
  - An ACK accepted at DEBT==0 increments credit.
  - An owe event with credit>0 decrements credit instead of incrementing DEBT.
  - ENABLE low or reset clears credit.
- Not defined:
  - No credit logic exists, and there are no pull-in requests.
  - REF_REQ depends solely on DEBT!=0.

Test Plan:
1. Reset, ENABLE=1, 28 TICK_IN rising edges, no ACK -> DEBT=1, REF_REQ=1 within 4 CLK of the 28th edge; REF_URGENT=0.
2. With REF_REQ=1, pulse REF_ACK -> DEBT=0, REF_REQ low for 5 CLK, then stays low (S_IDLE).
3. Run 6x28 ticks with no ACK -> DEBT=6, REF_URGENT=1. One ACK -> DEBT=5, REF_URGENT=0. Continue to 9 intervals unacked -> DEBT=8, OVERFLOW=1 (sticky after later ACKs).
4. Align owe event and REF_ACK on the same CLK with DEBT=3 -> DEBT stays 3. REF_ACK in S_GUARD -> DEBT unchanged.
5. Assert REFRESH_RST mid S_REQ with DEBT=4 -> all outputs 0 asynchronously. ENABLE low for 100 ticks -> DEBT=0, REF_REQ=0.
6. With REFRESH_PULLIN_EN defined, DEBT=0, BUSY low -> 4 pull-in REQ/ACK pairs, credit=4. Next 4 intervals leave DEBT=0; the 5th gives DEBT=1.
